// File: rtl/wordle_guess_scorer.sv
// Wordle guess scorer: scores a five-letter guess against an answer over
// a fixed 12-cycle sequence (green pass, yellow pass, write-back) and keeps
// a six-row history of results for the display stage.
module wordle_guess_scorer (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  row,
    input  logic [39:0] guess,
    input  logic [39:0] answer,
    input  logic        clear,
    input  logic [2:0]  rd_row,
    output logic [9:0]  rd_result,
    output logic [9:0]  result,
    output logic        win,
    output logic        busy,
    output logic        done
);

    localparam int unsigned NPOS  = 5;
    localparam int unsigned LW    = 8;
    localparam int unsigned CW    = 2;
    localparam int unsigned RW    = NPOS * CW;
    localparam int unsigned NROWS = 6;

    localparam logic [CW-1:0] C_GRAY   = 2'b01;
    localparam logic [CW-1:0] C_YELLOW = 2'b10;
    localparam logic [CW-1:0] C_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [39:0]         guess_q, guess_d;
    logic [39:0]         answer_q, answer_d;
    logic [2:0]          row_q, row_d;
    logic [CW-1:0]       code_q [NPOS];
    logic [CW-1:0]       code_d [NPOS];
    logic [NPOS-1:0]     used_q, used_d;
    logic [RW-1:0]       result_d;
    logic                win_d;
    logic                busy_d;
    logic                done_d;
    logic                hist_we;
    logic                hist_clr;
    logic [RW-1:0]       hist [NROWS];

    logic [LW-1:0]       g_let [NPOS];
    logic [LW-1:0]       a_let [NPOS];
    logic [LW-1:0]       cur_g;
    logic [LW-1:0]       cur_a;
    logic [CW-1:0]       cur_code;
    logic [NPOS-1:0]     sel;
    logic [RW-1:0]       code_pk;

    // Unpack latched words into per-position letters, select the current position and pack the working code.
    always_comb begin
        cur_g    = '0;
        cur_a    = '0;
        cur_code = '0;
        code_pk  = '0;
        for (int p = 0; p < NPOS; p++) begin
            g_let[p] = guess_q[LW*(NPOS-1-p) +: LW];
            a_let[p] = answer_q[LW*(NPOS-1-p) +: LW];
            code_pk[CW*(NPOS-1-p) +: CW] = code_q[p];
            if (idx_q == 3'(p)) begin
                cur_g    = guess_q[LW*(NPOS-1-p) +: LW];
                cur_a    = answer_q[LW*(NPOS-1-p) +: LW];
                cur_code = code_q[p];
            end
        end
    end

    // Lowest unused answer position holding the current guess letter (one-hot, zero if none).
    always_comb begin
        sel = '0;
        for (int j = NPOS - 1; j >= 0; j--) begin
            if (!used_q[j] && (a_let[j] == cur_g)) begin
                sel    = '0;
                sel[j] = 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        guess_d  = guess_q;
        answer_d = answer_q;
        row_d    = row_q;
        code_d   = code_q;
        used_d   = used_q;
        result_d = result;
        win_d    = win;
        done_d   = 1'b0;
        hist_we  = 1'b0;
        hist_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    hist_clr = 1'b1;
                    result_d = '0;
                    win_d    = 1'b0;
                end else if (start && (row < 3'(NROWS))) begin
                    guess_d  = guess;
                    answer_d = answer;
                    row_d    = row;
                    for (int p = 0; p < NPOS; p++) code_d[p] = '0;
                    used_d   = '0;
                    idx_d    = '0;
                    state_d  = S_GREEN;
                end
            end
            S_GREEN: begin
                if (cur_g == cur_a) begin
                    for (int p = 0; p < NPOS; p++) begin
                        if (idx_q == 3'(p)) begin
                            code_d[p] = C_GREEN;
                            used_d[p] = 1'b1;
                        end
                    end
                end
                if (idx_q == 3'(NPOS - 1)) begin
                    idx_d   = '0;
                    state_d = S_YELLOW;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_YELLOW: begin
                if (cur_code != C_GREEN) begin
                    used_d = used_q | sel;
                    for (int p = 0; p < NPOS; p++) begin
                        if (idx_q == 3'(p)) code_d[p] = (|sel) ? C_YELLOW : C_GRAY;
                    end
                end
                if (idx_q == 3'(NPOS - 1)) begin
                    idx_d   = '0;
                    state_d = S_WRITE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_WRITE: begin
                result_d = code_pk;
                win_d    = (code_pk == {RW{1'b1}});
                hist_we  = 1'b1;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            guess_q  <= '0;
            answer_q <= '0;
            row_q    <= '0;
            for (int p = 0; p < NPOS; p++) code_q[p] <= '0;
            used_q   <= '0;
            result   <= '0;
            win      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            guess_q  <= guess_d;
            answer_q <= answer_d;
            row_q    <= row_d;
            code_q   <= code_d;
            used_q   <= used_d;
            result   <= result_d;
            win      <= win_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // History rows: wiped by clear, written once per scored guess.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NROWS; r++) hist[r] <= '0;
        end else if (hist_clr) begin
            for (int r = 0; r < NROWS; r++) hist[r] <= '0;
        end else if (hist_we) begin
            for (int r = 0; r < NROWS; r++) begin
                if (row_q == 3'(r)) hist[r] <= code_pk;
            end
        end
    end

    // Combinational history read port; unused addresses read as zero.
    always_comb begin
        rd_result = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (rd_row == 3'(r)) rd_result = hist[r];
        end
    end

endmodule

// File: tb/tb_wordle_guess_scorer.sv
// Self-checking bench for wordle_guess_scorer: directed cases plus random
// guesses scored by a letter-count reference model.
module tb_wordle_guess_scorer;

    logic        board_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  row;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        clear;
    logic [2:0]  rd_row;
    logic [9:0]  rd_result;
    logic [9:0]  result;
    logic        win;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    bit [9:0]  hist_m [8];
    bit [9:0]  res_m;
    bit        win_m;

    wordle_guess_scorer dut (
        .board_clk (board_clk),
        .reset     (reset),
        .start     (start),
        .row       (row),
        .guess     (guess),
        .answer    (answer),
        .clear     (clear),
        .rd_row    (rd_row),
        .rd_result (rd_result),
        .result    (result),
        .win       (win),
        .busy      (busy),
        .done      (done)
    );

    always #5 board_clk = ~board_clk;

    // Reference: greens first, then yellows consume remaining answer letter counts left to right.
    function automatic bit [9:0] model_score(input bit [39:0] g, input bit [39:0] a);
        bit [7:0] gl [5];
        bit [7:0] al [5];
        int       cnt [256];
        bit [1:0] c [5];
        bit [9:0] r;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        for (int p = 0; p < 5; p++) begin
            gl[p] = g[8*(4-p) +: 8];
            al[p] = a[8*(4-p) +: 8];
        end
        for (int p = 0; p < 5; p++) begin
            if (gl[p] == al[p]) c[p] = 2'd3;
            else begin
                c[p] = 2'd0;
                cnt[al[p]]++;
            end
        end
        for (int p = 0; p < 5; p++) begin
            if (c[p] != 2'd3) begin
                if (cnt[gl[p]] > 0) begin
                    c[p] = 2'd2;
                    cnt[gl[p]]--;
                end else c[p] = 2'd1;
            end
        end
        r = {c[0], c[1], c[2], c[3], c[4]};
        return r;
    endfunction

    // Drive one start request and watch until done, returning its cycle number and pulse count.
    task automatic run_score(input bit [2:0] r, input bit [39:0] g, input bit [39:0] a,
                             output int lat, output int ndone, output int busy_first);
        @(negedge board_clk);
        row = r; guess = g; answer = a; start = 1'b1;
        lat = 0; ndone = 0; busy_first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge board_clk);
            start = 1'b0;
            if (k == 1) busy_first = int'(busy);
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
            if (lat != 0 && k >= lat + 1) break;
        end
    endtask

    // Score one guess through the DUT and check result, win, latency and pulse width against the model.
    task automatic score_and_check(input string name, input bit [2:0] r,
                                   input bit [39:0] g, input bit [39:0] a);
        int lat, nd, bf;
        run_score(r, g, a, lat, nd, bf);
        res_m = model_score(g, a);
        win_m = (res_m == 10'h3FF);
        if (r <= 3'd5) hist_m[r] = res_m;
        n_cmp++;
        if (lat !== 12) begin n_bad++; $display("FAIL %s latency: got %0d want 12", name, lat); end
        n_cmp++;
        if (nd !== 1) begin n_bad++; $display("FAIL %s done_pulses: got %0d want 1", name, nd); end
        n_cmp++;
        if (bf !== 1) begin n_bad++; $display("FAIL %s busy_after_start: got %0d want 1", name, bf); end
        n_cmp++;
        if (result !== res_m) begin n_bad++; $display("FAIL %s result: got %h want %h", name, result, res_m); end
        n_cmp++;
        if (win !== win_m) begin n_bad++; $display("FAIL %s win: got %b want %b", name, win, win_m); end
    endtask

    // Compare every history address (including 6 and 7) against the model.
    task automatic check_history(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            #1;
            n_cmp++;
            if (rd_result !== hist_m[i]) begin
                n_bad++;
                $display("FAIL %s rd_result[%0d]: got %h want %h", name, i, rd_result, hist_m[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clear = 1'b0; row = '0; guess = '0; answer = '0; rd_row = '0;
        for (int i = 0; i < 8; i++) hist_m[i] = '0;
        repeat (3) @(negedge board_clk);
        reset = 1'b0;
        @(negedge board_clk);
        n_cmp++;
        if ({result, win, busy, done} !== 13'd0) begin
            n_bad++; $display("FAIL reset_outputs: got result=%h win=%b busy=%b done=%b want all 0", result, win, busy, done);
        end
        check_history("reset");
    endtask

    task automatic test_directed();
        score_and_check("crane_win", 3'd0, "CRANE", "CRANE");
        n_cmp++;
        if (result !== 10'h3FF || win !== 1'b1) begin n_bad++; $display("FAIL crane_const: got %h/%b want 3ff/1", result, win); end
        score_and_check("nacre", 3'd1, "NACRE", "CRANE");
        n_cmp++;
        if (result !== 10'h2AB) begin n_bad++; $display("FAIL nacre_const: got %h want 2ab", result); end
        score_and_check("bobby", 3'd2, "BOBBY", "ABBEY");
        n_cmp++;
        if (result !== 10'h277) begin n_bad++; $display("FAIL bobby_const: got %h want 277", result); end
        check_history("directed");
    endtask

    task automatic test_random();
        bit [39:0] g, a;
        bit [2:0]  r;
        for (int it = 0; it < 30; it++) begin
            for (int p = 0; p < 5; p++) begin
                // Small alphabet to force duplicates; occasional raw byte including lower case.
                g[8*p +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h41 + $urandom_range(0, 3));
                a[8*p +: 8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(8'h41 + $urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) g = a;
            r = 3'($urandom_range(0, 5));
            score_and_check("random", r, g, a);
        end
        check_history("random");
    endtask

    // Start and clear while busy are ignored; row 6 from idle is ignored.
    task automatic test_busy_ignore();
        int nd, lat;
        bit [9:0] r3_before;
        @(negedge board_clk);
        row = 3'd4; guess = "SLATE"; answer = "STALE"; start = 1'b1;
        nd = 0; lat = 0;
        r3_before = hist_m[3];
        for (int k = 1; k <= 30; k++) begin
            @(negedge board_clk);
            start = 1'b0; clear = 1'b0;
            if (k == 3) begin row = 3'd3; guess = "AAAAA"; answer = "AAAAA"; start = 1'b1; end
            if (k == 5) clear = 1'b1;
            if (done) begin nd++; if (lat == 0) lat = k; end
        end
        res_m = model_score("SLATE", "STALE");
        hist_m[4] = res_m;
        n_cmp++;
        if (nd !== 1 || lat !== 12) begin n_bad++; $display("FAIL busy_ignore done: got %0d pulses at %0d want 1 at 12", nd, lat); end
        n_cmp++;
        if (result !== res_m) begin n_bad++; $display("FAIL busy_ignore result: got %h want %h", result, res_m); end
        n_cmp++;
        if (hist_m[3] !== r3_before) begin n_bad++; $display("FAIL busy_ignore model_row3"); end
        check_history("busy_ignore");

        @(negedge board_clk);
        row = 3'd6; guess = "AAAAA"; answer = "AAAAA"; start = 1'b1;
        nd = 0; lat = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge board_clk);
            start = 1'b0;
            if (done || busy) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL row6_ignored: got %0d busy/done cycles want 0", nd); end
        n_cmp++;
        if (result !== res_m) begin n_bad++; $display("FAIL row6_result: got %h want %h", result, res_m); end
        check_history("row6");
    endtask

    task automatic test_overwrite();
        score_and_check("overwrite", 3'd4, "CRANE", "CRANE");
        check_history("overwrite");
    endtask

    // Reset while in GREEN at idx 2: immediate abort, nothing written.
    task automatic test_reset_mid();
        int nd;
        @(negedge board_clk);
        row = 3'd5; guess = "CRANE"; answer = "CRANE"; start = 1'b1;
        repeat (3) begin @(negedge board_clk); start = 1'b0; end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid busy: got %b want 0", busy); end
        @(negedge board_clk);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin @(negedge board_clk); if (done) nd++; end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL reset_mid done: got %0d want 0", nd); end
        n_cmp++;
        if (result !== 10'd0 || win !== 1'b0) begin n_bad++; $display("FAIL reset_mid result: got %h/%b want 0/0", result, win); end
        for (int i = 0; i < 8; i++) hist_m[i] = '0;
        check_history("reset_mid");
    endtask

    // Fill all rows, then clear; also clear together with start.
    task automatic test_clear();
        int nd;
        for (int r = 0; r < 6; r++) score_and_check("fill", 3'(r), (r == 5) ? "CRANE" : "NACRE", "CRANE");
        check_history("fill");
        @(negedge board_clk);
        clear = 1'b1;
        @(negedge board_clk);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) hist_m[i] = '0;
        n_cmp++;
        if (result !== 10'd0 || win !== 1'b0) begin n_bad++; $display("FAIL clear result: got %h/%b want 0/0", result, win); end
        check_history("clear");

        score_and_check("pre_clear_start", 3'd2, "CRANE", "CRANE");
        @(negedge board_clk);
        clear = 1'b1; start = 1'b1; row = 3'd1; guess = "CRANE"; answer = "CRANE";
        @(negedge board_clk);
        clear = 1'b0; start = 1'b0;
        hist_m[2] = '0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin @(negedge board_clk); if (done || busy) nd++; end
        n_cmp++;
        if (nd !== 0) begin n_bad++; $display("FAIL clear_start busy/done: got %0d want 0", nd); end
        n_cmp++;
        if (result !== 10'd0 || win !== 1'b0) begin n_bad++; $display("FAIL clear_start result: got %h/%b want 0/0", result, win); end
        check_history("clear_start");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_overwrite();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wordle_guess_scorer.md
WORDLE_GUESS_SCORER -- requirements
Module: wordle_guess_scorer

Interface
REQ-001 SHALL have port board_clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request to score one guess, sampled only in IDLE.
REQ-004 SHALL have port row, input, 3 bits: history row (0-5) for the guess being scored, sampled with start.
REQ-005 SHALL have port guess, input, 40 bits: five 8-bit ASCII letters; [39:32] is position 0, [7:0] is position 4.
REQ-006 SHALL have port answer, input, 40 bits: target word, same packing as guess, sampled with start.
REQ-007 SHALL have port clear, input, 1 bit: wipe history, honoured only in IDLE.
REQ-008 SHALL have port rd_row, input, 3 bits: history read address for the VGA stage.
REQ-009 SHALL have port rd_result, output, 10 bits: combinational read of history[rd_row]; 0 when rd_row>5.
REQ-010 SHALL have port result, output, 10 bits: last scored result, 2 bits per position, [9:8] = position 0.
REQ-011 SHALL have port win, output, 1 bit: last result was all green.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when result, win and history are updated.

Function
REQ-014 Per-position code SHALL be: 00 empty/unscored, 01 gray, 10 yellow, 11 green.
REQ-015 States SHALL be IDLE, GREEN, YELLOW, WRITE, DONE, with a 3-bit position index idx.
REQ-016 In IDLE, start=1 with row<=5 SHALL latch guess, answer and row, clear the working result and used[4:0], set idx=0, and go to GREEN.
REQ-017 start with row>5 SHALL be ignored: state stays IDLE, no done.
REQ-018 start SHALL be ignored while busy.
REQ-019 GREEN (one position per cycle, idx 0..4): if guess[idx]==answer[idx], code[idx]=11 and used[idx]=1; at idx=4 go to YELLOW with idx=0.
REQ-020 YELLOW (one position per cycle, idx 0..4): if code[idx]!=11, find the lowest j with used[j]=0 and answer[j]==guess[idx]; if found, code[idx]=10 and used[j]=1, else code[idx]=01; at idx=4 go to WRITE.
REQ-021 Duplicate letters SHALL be marked yellow/green at most as many times as they occur in answer; earlier guess positions take priority for yellow.
REQ-022 WRITE SHALL copy the working result to result and to history[row], set win=(result==10'h3FF), and go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 Latency: done SHALL be high during the cycle following the 11th rising edge after the edge that samples start (12 cycles start-to-done inclusive).
REQ-025 Letter comparison SHALL be a raw 8-bit equality; no case folding or validation.
REQ-026 clear=1 in IDLE SHALL zero all six history rows, result and win on the next edge; clear while busy SHALL be ignored.
REQ-027 clear and start together in IDLE: clear SHALL take effect and start SHALL be ignored.
REQ-028 Rescoring an already-written row SHALL overwrite it.

Reset
REQ-029 reset SHALL force IDLE and set idx=0, used=0, result=0, win=0, busy=0, done=0, and all history rows to 0.
REQ-030 reset mid-operation SHALL abort the operation: no done pulse and no history write.

Verification
REQ-031 answer "CRANE", guess "CRANE", row 0 -> result=10'h3FF, win=1, done 12 cycles after start, rd_result(0)=10'h3FF.
REQ-032 answer "CRANE", guess "NACRE", row 1 -> result=10'h2AB (Y,Y,Y,Y,G), win=0.
REQ-033 answer "ABBEY", guess "BOBBY", row 2 -> result=10'h277 (Y,gray,G,gray,G); the duplicate B at position 3 is gray.
REQ-034 Second start while busy, and start with row=6 from IDLE -> both ignored: exactly one done, history unchanged by the row=6 request.
REQ-035 reset asserted during the GREEN cycle at idx=2 -> busy=0 immediately, no done, all rd_result rows 0.
REQ-036 Score rows 0-5, then assert clear in IDLE -> rd_result=0 for rd_row 0-7, result=0, win=0.
